// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, ex_op encodings,
// status/interrupt bit positions and interrupt cause codes.
package csr_pkg;

  typedef enum logic [1:0] {
    EX_NONE  = 2'b00,
    EX_WRITE = 2'b01,
    EX_SET   = 2'b10,
    EX_CLEAR = 2'b11
  } ex_op_e;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LSB  = 11;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  localparam int unsigned CAUSE_M_TIMER = 7;
  localparam int unsigned CAUSE_M_EXT   = 11;

endpackage

// File: rtl/csr_unit_counter.sv
// One CNT_WIDTH event counter with inhibit and split low/high half access.
module csr_counter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  input  logic                  inhibit_i,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_lo_o,
  output logic [DATA_WIDTH-1:0] rdata_hi_o
);

  localparam int unsigned HI_W = CNT_WIDTH - DATA_WIDTH;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A half write suppresses the increment and never carries into the other half.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[DATA_WIDTH-1:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_WIDTH-1:DATA_WIDTH] = wdata_i[HI_W-1:0];
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rdata_lo_o = cnt_q[DATA_WIDTH-1:0];
  assign rdata_hi_o = DATA_WIDTH'(cnt_q[CNT_WIDTH-1:DATA_WIDTH]);

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: RMW access from ex, trap/mret sequencing from clint,
// interrupt request generation and mcycle/minstret/mhpmcounter counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned CNT_WIDTH      = 64,
  parameter int unsigned HPM_COUNT      = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [1:0]                                   ex_op_i,
  input  logic [CSR_ADDR_WIDTH-1:0]                    ex_addr_i,
  input  logic [DATA_WIDTH-1:0]                        ex_wdata_i,
  output logic [DATA_WIDTH-1:0]                        ex_rdata_o,
  output logic                                         ex_illegal_o,
  input  logic                                         instret_i,
  input  logic [((HPM_COUNT > 0) ? HPM_COUNT : 1)-1:0] hpm_event_i,
  input  logic                                         trap_i,
  input  logic [DATA_WIDTH-1:0]                        trap_cause_i,
  input  logic [DATA_WIDTH-1:0]                        trap_pc_i,
  input  logic                                         mret_i,
  input  logic                                         irq_timer_i,
  input  logic                                         irq_ext_i,
  output logic [DATA_WIDTH-1:0]                        mtvec_o,
  output logic [DATA_WIDTH-1:0]                        mepc_o,
  output logic                                         int_req_o,
  output logic [DATA_WIDTH-1:0]                        int_cause_o
);

  localparam int unsigned NCNT = 2 + HPM_COUNT;
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK  = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] CINH_MASK   =
    DATA_WIDTH'((((64'd1 << HPM_COUNT) - 64'd1) << 3) | 64'd5);
  localparam logic [DATA_WIDTH-1:0] CAUSE_EXT   =
    {1'b1, {(DATA_WIDTH-1){1'b0}}} | DATA_WIDTH'(CAUSE_M_EXT);
  localparam logic [DATA_WIDTH-1:0] CAUSE_TIMER =
    {1'b1, {(DATA_WIDTH-1){1'b0}}} | DATA_WIDTH'(CAUSE_M_TIMER);

  logic [11:0] addr;
  ex_op_e      op;

  logic mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic mie_mtie_q, mie_mtie_d, mie_meie_q, mie_meie_d;
  logic mip_mtip_q, mip_mtip_d, mip_meip_q, mip_meip_d;
  logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [DATA_WIDTH-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [DATA_WIDTH-1:0] mcinh_q, mcinh_d;

  logic [DATA_WIDTH-1:0] rdata, wval;
  logic                  hit, illegal, wr_en, busy;
  logic                  cnt_region, cnt_hit, cnt_hi;
  int unsigned           cnt_n, cnt_slot;
  logic [DATA_WIDTH-1:0] cnt_lo_rd [NCNT];
  logic [DATA_WIDTH-1:0] cnt_hi_rd [NCNT];
  logic [NCNT-1:0]       cnt_wr_lo, cnt_wr_hi;
  logic                  ext_pend, tim_pend;

  assign addr = 12'(ex_addr_i);
  assign op   = ex_op_e'(ex_op_i);

  // Counter addresses: slot 0 = cycle (n=0), slot 1 = instret (n=2), slot 2+i = hpm(3+i).
  always_comb begin
    cnt_n      = 32'(addr[4:0]);
    cnt_hi     = addr[7];
    cnt_region = addr[11:5] inside {CSR_MCYCLE[11:5], CSR_MCYCLEH[11:5],
                                    CSR_CYCLE[11:5], CSR_CYCLEH[11:5]};
    cnt_hit    = cnt_region &&
                 (cnt_n == 0 || cnt_n == 2 || (cnt_n >= 3 && cnt_n < 3 + HPM_COUNT));
    cnt_slot   = (cnt_n == 0) ? 0 : cnt_n - 1;
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (addr)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE_BIT]           = mst_mie_q;
        rdata[MSTATUS_MPIE_BIT]          = mst_mpie_q;
        rdata[MSTATUS_MPP_LSB +: 2]      = 2'b11;
      end
      CSR_MIE: begin
        rdata[MIE_MTIE_BIT] = mie_mtie_q;
        rdata[MIE_MEIE_BIT] = mie_meie_q;
      end
      CSR_MIP: begin
        rdata[MIP_MTIP_BIT] = mip_mtip_q;
        rdata[MIP_MEIP_BIT] = mip_meip_q;
      end
      CSR_MTVEC:         rdata = mtvec_q;
      CSR_MCOUNTINHIBIT: rdata = mcinh_q;
      CSR_MSCRATCH:      rdata = mscratch_q;
      CSR_MEPC:          rdata = mepc_q;
      CSR_MCAUSE:        rdata = mcause_q;
      default: begin
        if (cnt_hit) rdata = cnt_hi ? cnt_hi_rd[cnt_slot] : cnt_lo_rd[cnt_slot];
        else         hit   = 1'b0;
      end
    endcase
  end

  assign illegal      = !hit || ((addr[11:10] == 2'b11) && (op != EX_NONE));
  assign wr_en        = (op != EX_NONE) && !illegal;
  assign ex_rdata_o   = rdata;
  assign ex_illegal_o = illegal;

  always_comb begin
    case (op)
      EX_WRITE: wval = ex_wdata_i;
      EX_SET:   wval = rdata | ex_wdata_i;
      EX_CLEAR: wval = rdata & ~ex_wdata_i;
      default:  wval = '0;
    endcase
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_mtie_d = mie_mtie_q;
    mie_meie_d = mie_meie_q;
    mip_mtip_d = irq_timer_i;
    mip_meip_d = irq_ext_i;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcinh_d    = mcinh_q;
    busy       = trap_i | mret_i;
    if (wr_en) begin
      case (addr)
        CSR_MSTATUS: if (!busy) begin
          mst_mie_d  = wval[MSTATUS_MIE_BIT];
          mst_mpie_d = wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mie_mtie_d = wval[MIE_MTIE_BIT];
          mie_meie_d = wval[MIE_MEIE_BIT];
        end
        CSR_MTVEC:         mtvec_d    = wval & ALIGN_MASK;
        CSR_MCOUNTINHIBIT: mcinh_d    = wval & CINH_MASK;
        CSR_MSCRATCH:      mscratch_d = wval;
        CSR_MEPC:          if (!busy) mepc_d   = wval & ALIGN_MASK;
        CSR_MCAUSE:        if (!busy) mcause_d = wval;
        default: ;
      endcase
    end
    if (trap_i) begin
      mepc_d     = trap_pc_i & ALIGN_MASK;
      mcause_d   = trap_cause_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  always_comb begin
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    if (wr_en && cnt_hit) begin
      if (cnt_hi) cnt_wr_hi[cnt_slot] = 1'b1;
      else        cnt_wr_lo[cnt_slot] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_mtie_q <= 1'b0;
      mie_meie_q <= 1'b0;
      mip_mtip_q <= 1'b0;
      mip_meip_q <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcinh_q    <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_mtie_q <= mie_mtie_d;
      mie_meie_q <= mie_meie_d;
      mip_mtip_q <= mip_mtip_d;
      mip_meip_q <= mip_meip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcinh_q    <= mcinh_d;
    end
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    logic inc, inh;
    if (g == 0) begin : g_cycle
      assign inc = 1'b1;
      assign inh = mcinh_q[0];
    end else if (g == 1) begin : g_instret
      assign inc = instret_i;
      assign inh = mcinh_q[2];
    end else begin : g_hpm
      assign inc = hpm_event_i[g-2];
      assign inh = mcinh_q[g+1];
    end
    csr_counter #(
      .DATA_WIDTH(DATA_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (inc),
      .inhibit_i (inh),
      .wr_lo_i   (cnt_wr_lo[g]),
      .wr_hi_i   (cnt_wr_hi[g]),
      .wdata_i   (wval),
      .rdata_lo_o(cnt_lo_rd[g]),
      .rdata_hi_o(cnt_hi_rd[g])
    );
  end

  assign ext_pend    = mst_mie_q & mie_meie_q & mip_meip_q;
  assign tim_pend    = mst_mie_q & mie_mtie_q & mip_mtip_q;
  assign int_req_o   = ext_pend | tim_pend;
  assign int_cause_o = ext_pend ? CAUSE_EXT : (tim_pend ? CAUSE_TIMER : '0);
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit with default parameters.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ex_op_i = 2'b00;
  logic [11:0] ex_addr_i = 12'h340;
  logic [31:0] ex_wdata_i = '0;
  logic [31:0] ex_rdata_o;
  logic        ex_illegal_o;
  logic        instret_i = 1'b0;
  logic [1:0]  hpm_event_i = 2'b00;
  logic        trap_i = 1'b0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_pc_i = '0;
  logic        mret_i = 1'b0;
  logic        irq_timer_i = 1'b0;
  logic        irq_ext_i = 1'b0;
  logic [31:0] mtvec_o, mepc_o, int_cause_o;
  logic        int_req_o;

  int total = 0;
  int bad = 0;
  logic [31:0] rd, rd2;
  logic        ill;

  always #5 clk = ~clk;

  csr_unit #(
    .DATA_WIDTH    (32),
    .CSR_ADDR_WIDTH(12),
    .CNT_WIDTH     (64),
    .HPM_COUNT     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_op_i     (ex_op_i),
    .ex_addr_i   (ex_addr_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_rdata_o  (ex_rdata_o),
    .ex_illegal_o(ex_illegal_o),
    .instret_i   (instret_i),
    .hpm_event_i (hpm_event_i),
    .trap_i      (trap_i),
    .trap_cause_i(trap_cause_i),
    .trap_pc_i   (trap_pc_i),
    .mret_i      (mret_i),
    .irq_timer_i (irq_timer_i),
    .irq_ext_i   (irq_ext_i),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o),
    .int_req_o   (int_req_o),
    .int_cause_o (int_cause_o)
  );

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    ex_op_i = op; ex_addr_i = a; ex_wdata_i = d;
    @(negedge clk);
    ex_op_i = 2'b00;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic il);
    ex_op_i = 2'b00; ex_addr_i = a;
    #1;
    d = ex_rdata_o; il = ex_illegal_o;
  endtask

  task automatic test_reset;
    #12;
    total++; if (ex_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=%h", ex_rdata_o, 32'h0); end
    total++; if (ex_illegal_o !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b exp=0", ex_illegal_o); end
    total++; if (mtvec_o !== 32'h0) begin bad++; $display("FAIL rst_mtvec got=%h exp=0", mtvec_o); end
    total++; if (mepc_o !== 32'h0) begin bad++; $display("FAIL rst_mepc got=%h exp=0", mepc_o); end
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL rst_intreq got=%b exp=0", int_req_o); end
    total++; if (int_cause_o !== 32'h0) begin bad++; $display("FAIL rst_cause got=%h exp=0", int_cause_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1800) begin bad++; $display("FAIL rst_mstatus got=%h exp=%h", rd, 32'h1800); end
  endtask

  task automatic test_rmw;
    csr_wr(2'b01, 12'h305, 32'h80000103);
    csr_rd(12'h305, rd, ill);
    total++; if (rd !== 32'h80000100) begin bad++; $display("FAIL mtvec_rd got=%h exp=%h", rd, 32'h80000100); end
    total++; if (mtvec_o !== 32'h80000100) begin bad++; $display("FAIL mtvec_o got=%h exp=%h", mtvec_o, 32'h80000100); end
    csr_wr(2'b01, 12'h340, 32'hA5A50000);
    csr_wr(2'b10, 12'h340, 32'h0000000F);
    csr_wr(2'b11, 12'h340, 32'hA0000000);
    csr_rd(12'h340, rd, ill);
    total++; if (rd !== 32'h05A5000F) begin bad++; $display("FAIL mscratch_rmw got=%h exp=%h", rd, 32'h05A5000F); end
    csr_wr(2'b01, 12'h304, 32'hFFFFFFFF);
    csr_rd(12'h304, rd, ill);
    total++; if (rd !== 32'h880) begin bad++; $display("FAIL mie_mask got=%h exp=%h", rd, 32'h880); end
    csr_wr(2'b01, 12'h304, 32'h0);
  endtask

  task automatic test_trap;
    csr_wr(2'b01, 12'h300, 32'h8);
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1808) begin bad++; $display("FAIL mstatus_wr got=%h exp=%h", rd, 32'h1808); end
    trap_i = 1'b1; trap_pc_i = 32'h1006; trap_cause_i = 32'h7;
    @(negedge clk); trap_i = 1'b0;
    csr_rd(12'h341, rd, ill);
    total++; if (rd !== 32'h1004) begin bad++; $display("FAIL trap_mepc got=%h exp=%h", rd, 32'h1004); end
    total++; if (mepc_o !== 32'h1004) begin bad++; $display("FAIL trap_mepc_o got=%h exp=%h", mepc_o, 32'h1004); end
    csr_rd(12'h342, rd, ill);
    total++; if (rd !== 32'h7) begin bad++; $display("FAIL trap_mcause got=%h exp=%h", rd, 32'h7); end
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1880) begin bad++; $display("FAIL trap_mstatus got=%h exp=%h", rd, 32'h1880); end
    mret_i = 1'b1;
    @(negedge clk); mret_i = 1'b0;
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=%h", rd, 32'h1888); end
    csr_wr(2'b01, 12'h300, 32'hFFFFFFFF);
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1888) begin bad++; $display("FAIL mstatus_mask got=%h exp=%h", rd, 32'h1888); end
  endtask

  task automatic test_priority;
    trap_i = 1'b1; trap_pc_i = 32'h2000; trap_cause_i = 32'hB;
    csr_wr(2'b01, 12'h341, 32'hDEAD0000);
    trap_i = 1'b0;
    csr_rd(12'h341, rd, ill);
    total++; if (rd !== 32'h2000) begin bad++; $display("FAIL prio_mepc got=%h exp=%h", rd, 32'h2000); end
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1880) begin bad++; $display("FAIL prio_mstatus1 got=%h exp=%h", rd, 32'h1880); end
    trap_i = 1'b1; trap_pc_i = 32'h3000; trap_cause_i = 32'h2;
    csr_wr(2'b10, 12'h304, 32'h80);
    trap_i = 1'b0;
    csr_rd(12'h304, rd, ill);
    total++; if (rd !== 32'h80) begin bad++; $display("FAIL prio_mie got=%h exp=%h", rd, 32'h80); end
    csr_rd(12'h342, rd, ill);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL prio_mcause got=%h exp=%h", rd, 32'h2); end
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1800) begin bad++; $display("FAIL prio_mstatus2 got=%h exp=%h", rd, 32'h1800); end
    mret_i = 1'b1;
    csr_wr(2'b01, 12'h300, 32'h0);
    mret_i = 1'b0;
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1880) begin bad++; $display("FAIL prio_mret got=%h exp=%h", rd, 32'h1880); end
  endtask

  task automatic test_irq;
    csr_wr(2'b01, 12'h304, 32'h880);
    csr_wr(2'b01, 12'h300, 32'h8);
    irq_ext_i = 1'b1; irq_timer_i = 1'b1;
    #1;
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL irq_latency got=%b exp=0", int_req_o); end
    @(negedge clk);
    total++; if (int_req_o !== 1'b1) begin bad++; $display("FAIL irq_req got=%b exp=1", int_req_o); end
    total++; if (int_cause_o !== 32'h8000000B) begin bad++; $display("FAIL irq_ext_cause got=%h exp=%h", int_cause_o, 32'h8000000B); end
    csr_rd(12'h344, rd, ill);
    total++; if (rd !== 32'h880) begin bad++; $display("FAIL irq_mip got=%h exp=%h", rd, 32'h880); end
    irq_ext_i = 1'b0;
    @(negedge clk);
    total++; if (int_cause_o !== 32'h80000007) begin bad++; $display("FAIL irq_tim_cause got=%h exp=%h", int_cause_o, 32'h80000007); end
    csr_wr(2'b11, 12'h300, 32'h8);
    #1;
    total++; if (int_req_o !== 1'b0) begin bad++; $display("FAIL irq_gated got=%b exp=0", int_req_o); end
    total++; if (int_cause_o !== 32'h0) begin bad++; $display("FAIL irq_gated_cause got=%h exp=0", int_cause_o); end
    irq_timer_i = 1'b0;
  endtask

  task automatic test_counters;
    csr_wr(2'b01, 12'hB00, 32'hFFFFFFFF);
    csr_wr(2'b01, 12'hB80, 32'h0);
    csr_rd(12'hB00, rd, ill); csr_rd(12'hB80, rd2, ill);
    total++; if ({rd2, rd} !== 64'h0_FFFFFFFF) begin bad++; $display("FAIL mcycle_wr got=%h exp=%h", {rd2, rd}, 64'h0_FFFFFFFF); end
    @(negedge clk);
    csr_rd(12'hB00, rd, ill); csr_rd(12'hB80, rd2, ill);
    total++; if ({rd2, rd} !== 64'h1_00000000) begin bad++; $display("FAIL mcycle_carry got=%h exp=%h", {rd2, rd}, 64'h1_00000000); end
    csr_rd(12'hC80, rd2, ill);
    total++; if (rd2 !== 32'h1 || ill !== 1'b0) begin bad++; $display("FAIL cycleh_shadow got=%h/%b exp=1/0", rd2, ill); end
    csr_wr(2'b01, 12'h320, 32'hFFFFFFFF);
    csr_rd(12'h320, rd, ill);
    total++; if (rd !== 32'h1D) begin bad++; $display("FAIL cinh_mask got=%h exp=%h", rd, 32'h1D); end
    repeat (3) @(negedge clk);
    csr_rd(12'hB00, rd, ill); csr_rd(12'hB80, rd2, ill);
    total++; if ({rd2, rd} !== 64'h1_00000001) begin bad++; $display("FAIL mcycle_frozen got=%h exp=%h", {rd2, rd}, 64'h1_00000001); end
    csr_wr(2'b11, 12'h320, 32'h4);
    instret_i = 1'b1; hpm_event_i = 2'b11;
    repeat (3) @(negedge clk);
    instret_i = 1'b0; hpm_event_i = 2'b00;
    csr_rd(12'hB02, rd, ill);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL minstret got=%h exp=%h", rd, 32'h3); end
    csr_rd(12'hB03, rd, ill);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL hpm3_inhibit got=%h exp=0", rd); end
    csr_wr(2'b11, 12'h320, 32'h18);
    hpm_event_i = 2'b01;
    repeat (2) @(negedge clk);
    hpm_event_i = 2'b00;
    csr_rd(12'hB03, rd, ill);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL hpm3_count got=%h exp=%h", rd, 32'h2); end
    csr_rd(12'hC03, rd, ill);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL hpm3_shadow got=%h exp=%h", rd, 32'h2); end
    csr_rd(12'hB04, rd, ill);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL hpm4_count got=%h exp=0", rd); end
    csr_rd(12'hB05, rd, ill);
    total++; if (rd !== 32'h0 || ill !== 1'b1) begin bad++; $display("FAIL hpm5_absent got=%h/%b exp=0/1", rd, ill); end
    csr_wr(2'b11, 12'h320, 32'h1);
    csr_wr(2'b01, 12'hB00, 32'hFFFFFFFF);
    csr_wr(2'b01, 12'hB80, 32'hFFFFFFFF);
    csr_rd(12'hB00, rd, ill); csr_rd(12'hB80, rd2, ill);
    total++; if ({rd2, rd} !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("FAIL mcycle_ones got=%h exp=all-ones", {rd2, rd}); end
    @(negedge clk);
    csr_rd(12'hB00, rd, ill); csr_rd(12'hB80, rd2, ill);
    total++; if ({rd2, rd} !== 64'h0) begin bad++; $display("FAIL mcycle_wrap got=%h exp=0", {rd2, rd}); end
  endtask

  task automatic test_illegal;
    ex_op_i = 2'b01; ex_addr_i = 12'hC00; ex_wdata_i = 32'h1234;
    #1;
    total++; if (ex_illegal_o !== 1'b1) begin bad++; $display("FAIL ro_cycle_ill got=%b exp=1", ex_illegal_o); end
    @(negedge clk);
    ex_op_i = 2'b01; ex_addr_i = 12'hC02; ex_wdata_i = 32'hFFFF;
    #1;
    total++; if (ex_illegal_o !== 1'b1) begin bad++; $display("FAIL ro_instret_ill got=%b exp=1", ex_illegal_o); end
    @(negedge clk);
    ex_op_i = 2'b00;
    csr_rd(12'hB02, rd, ill);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL ro_nochange got=%h exp=%h", rd, 32'h3); end
    csr_rd(12'h7C0, rd, ill);
    total++; if (rd !== 32'h0 || ill !== 1'b1) begin bad++; $display("FAIL unimpl_rd got=%h/%b exp=0/1", rd, ill); end
    csr_rd(12'h340, rd, ill);
    total++; if (ill !== 1'b0) begin bad++; $display("FAIL legal_rd got=%b exp=0", ill); end
  endtask

  task automatic test_back_to_back;
    ex_op_i = 2'b01; ex_addr_i = 12'h340; ex_wdata_i = 32'h22222222;
    #1;
    total++; if (ex_rdata_o !== 32'h05A5000F) begin bad++; $display("FAIL b2b_noforward got=%h exp=%h", ex_rdata_o, 32'h05A5000F); end
    @(negedge clk);
    ex_op_i = 2'b10; ex_wdata_i = 32'h100;
    #1;
    total++; if (ex_rdata_o !== 32'h22222222) begin bad++; $display("FAIL b2b_wr got=%h exp=%h", ex_rdata_o, 32'h22222222); end
    @(negedge clk);
    ex_op_i = 2'b10; ex_wdata_i = 32'h1;
    #1;
    total++; if (ex_rdata_o !== 32'h22222322) begin bad++; $display("FAIL b2b_set1 got=%h exp=%h", ex_rdata_o, 32'h22222322); end
    @(negedge clk);
    ex_op_i = 2'b00;
    csr_rd(12'h340, rd, ill);
    total++; if (rd !== 32'h22222323) begin bad++; $display("FAIL b2b_set2 got=%h exp=%h", rd, 32'h22222323); end
  endtask

  task automatic test_reset_mid;
    trap_i = 1'b1; trap_pc_i = 32'h4000; trap_cause_i = 32'h5;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    trap_i = 1'b0;
    total++; if (mepc_o !== 32'h0) begin bad++; $display("FAIL midrst_mepc got=%h exp=0", mepc_o); end
    total++; if (mtvec_o !== 32'h0) begin bad++; $display("FAIL midrst_mtvec got=%h exp=0", mtvec_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    csr_rd(12'h342, rd, ill);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_mcause got=%h exp=0", rd); end
    csr_rd(12'h300, rd, ill);
    total++; if (rd !== 32'h1800) begin bad++; $display("FAIL midrst_mstatus got=%h exp=%h", rd, 32'h1800); end
    csr_rd(12'h340, rd, ill);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_mscratch got=%h exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_rmw();
    test_trap();
    test_priority();
    test_irq();
    test_counters();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
